mem_arbiter: RTL and testbench

Shares the single-port program/data memory between two requesters: port 0 (CPU) and port 1 (I/O loader/debug master). Each cycle it grants at most one requester and muxes that requester's address, write enable and write data onto the memory port. Read data is returned to the owner one cycle later. Arbitration is round-robin, with an optional bus lock for multi-cycle sequences such as fetching two instruction words or a read-then-write move.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter_read_tracker.sv | 45 ++++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Covers the FSM state encoding, the requester IDs and the default widths.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      FREE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_e;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_IO  = 1'b1
   } port_id_e;

   localparam int DEF_ADDR_WIDTH   = 6;
   localparam int DEF_DATA_WIDTH   = 16;
   localparam int DEF_LOCK_TIMEOUT = 15;

   function automatic port_id_e other_port(input port_id_e p);
      return (p == PORT_CPU) ? PORT_IO : PORT_CPU;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester handshakes plus the shared memory port.
// The arbiter takes the slave side; requesters and the memory model take the master side.
interface mem_arbiter_if
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

   logic                  req0_valid;
   logic                  req0_we;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [DATA_WIDTH-1:0] req0_data;
   logic                  req0_lock;
   logic                  req0_grant;
   logic                  req0_rvalid;
   logic [DATA_WIDTH-1:0] req0_rdata;

   logic                  req1_valid;
   logic                  req1_we;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [DATA_WIDTH-1:0] req1_data;
   logic                  req1_lock;
   logic                  req1_grant;
   logic                  req1_rvalid;
   logic [DATA_WIDTH-1:0] req1_rdata;

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic [DATA_WIDTH-1:0] mem_in;
   logic                  lock_timeout;

   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_data, req0_lock,
      output req0_grant, req0_rvalid, req0_rdata,
      input  req1_valid, req1_we, req1_addr, req1_data, req1_lock,
      output req1_grant, req1_rvalid, req1_rdata,
      output mem_we, mem_addr, mem_data, lock_timeout,
      input  mem_in
   );

   modport master (
      output req0_valid, req0_we, req0_addr, req0_data, req0_lock,
      input  req0_grant, req0_rvalid, req0_rdata,
      output req1_valid, req1_we, req1_addr, req1_data, req1_lock,
      input  req1_grant, req1_rvalid, req1_rdata,
      input  mem_we, mem_addr, mem_data, lock_timeout,
      output mem_in
   );

endinterface

// File: rtl/mem_arbiter_read_tracker.sv
// One-deep read return pipeline: remembers who issued last cycle's read and
// steers the memory's read data back to that requester only.
module arb_read_tracker
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_fire,
   input  port_id_e              rd_owner,
   input  logic [DATA_WIDTH-1:0] mem_in,
   output logic                  rvalid0,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata1
);

   logic     pending_q, pending_d;
   port_id_e owner_q, owner_d;

   always_comb begin
      pending_d = rd_fire;
      owner_d   = rd_fire ? rd_owner : owner_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= 1'b0;
         owner_q   <= PORT_CPU;
      end else begin
         pending_q <= pending_d;
         owner_q   <= owner_d;
      end
   end

   // Non-owner sees zero data so nothing stale leaks across ports.
   always_comb begin
      rvalid0 = pending_q && (owner_q == PORT_CPU);
      rvalid1 = pending_q && (owner_q == PORT_IO);
      rdata0  = rvalid0 ? mem_in : '0;
      rdata1  = rvalid1 ? mem_in : '0;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for a single-port memory shared by the CPU and the I/O
// master, with bus locking for multi-cycle sequences and a lock watchdog.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(LOCK_TIMEOUT);

   arb_state_e state_q, state_d;
   port_id_e   ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] cnt_inc;
   logic       grant0, grant1, timeout;
   logic       rd_fire;
   port_id_e   rd_owner;

   assign cnt_inc = cnt_q + 8'd1;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant0  = 1'b0;
      grant1  = 1'b0;
      timeout = 1'b0;
      unique case (state_q)
         FREE: begin
            cnt_d = '0;
            if (bus.req0_valid && (!bus.req1_valid || ptr_q == PORT_CPU)) begin
               grant0 = 1'b1;
            end else if (bus.req1_valid) begin
               grant1 = 1'b1;
            end
            // A locking grant keeps the pointer so the other side wins next.
            if (grant0) begin
               if (bus.req0_lock) state_d = LOCK0;
               else               ptr_d   = other_port(PORT_CPU);
            end else if (grant1) begin
               if (bus.req1_lock) state_d = LOCK1;
               else               ptr_d   = other_port(PORT_IO);
            end
         end
         LOCK0: begin
            grant0 = bus.req0_valid;
            if (!bus.req0_lock || cnt_inc == TIMEOUT_CNT) begin
               timeout = bus.req0_lock;
               state_d = FREE;
               ptr_d   = other_port(PORT_CPU);
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         LOCK1: begin
            grant1 = bus.req1_valid;
            if (!bus.req1_lock || cnt_inc == TIMEOUT_CNT) begin
               timeout = bus.req1_lock;
               state_d = FREE;
               ptr_d   = other_port(PORT_IO);
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = FREE;
            cnt_d   = '0;
         end
      endcase
      // Nothing is accepted while reset is held, even though grant is combinational.
      if (!rst_n) begin
         grant0  = 1'b0;
         grant1  = 1'b0;
         timeout = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FREE;
         ptr_q   <= PORT_CPU;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      bus.mem_we   = 1'b0;
      bus.mem_addr = ADDR_WIDTH'(0);
      bus.mem_data = '0;
      if (grant0) begin
         bus.mem_we   = bus.req0_we;
         bus.mem_addr = bus.req0_addr;
         bus.mem_data = bus.req0_data;
      end else if (grant1) begin
         bus.mem_we   = bus.req1_we;
         bus.mem_addr = bus.req1_addr;
         bus.mem_data = bus.req1_data;
      end
   end

   assign bus.req0_grant   = grant0;
   assign bus.req1_grant   = grant1;
   assign bus.lock_timeout = timeout;
   assign rd_fire  = (grant0 && !bus.req0_we) || (grant1 && !bus.req1_we);
   assign rd_owner = grant1 ? PORT_IO : PORT_CPU;

   arb_read_tracker #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_read_tracker (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_fire  (rd_fire),
      .rd_owner (rd_owner),
      .mem_in   (bus.mem_in),
      .rvalid0  (bus.req0_rvalid),
      .rdata0   (bus.req0_rdata),
      .rvalid1  (bus.req1_rvalid),
      .rdata1   (bus.req1_rdata)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run, all checked
// against a transaction-level model of the arbitration rules and a shadow memory.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int AW = 6;
   localparam int DW = 16;
   localparam int LT = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_TIMEOUT(LT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic          i_v [2];
   logic          i_we[2];
   logic          i_l [2];
   logic [AW-1:0] i_a [2];
   logic [DW-1:0] i_d [2];

   assign bus.req0_valid = i_v[0];
   assign bus.req0_we    = i_we[0];
   assign bus.req0_addr  = i_a[0];
   assign bus.req0_data  = i_d[0];
   assign bus.req0_lock  = i_l[0];
   assign bus.req1_valid = i_v[1];
   assign bus.req1_we    = i_we[1];
   assign bus.req1_addr  = i_a[1];
   assign bus.req1_data  = i_d[1];
   assign bus.req1_lock  = i_l[1];

   // Memory seen by the DUT: write at the edge, read data one cycle later.
   logic [DW-1:0] tb_mem[64];
   always @(posedge clk) begin
      if (bus.mem_we) tb_mem[bus.mem_addr] <= bus.mem_data;
      bus.mem_in <= tb_mem[bus.mem_addr];
   end

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: owner of the lock (-1 none), next preferred port,
   // consecutive locked cycles, outstanding read and a shadow memory.
   int            m_lock, m_ptr, m_cnt, m_owner;
   bit            m_pend;
   logic [DW-1:0] m_pdata;
   logic [DW-1:0] shadow[64];
   int            win;
   logic          e_g[2], e_rv[2];
   logic          e_to, e_we;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data;
   logic [DW-1:0] e_rd[2];
   logic [5:0]    got_c, exp_c;
   logic [53:0]   got_d, exp_d;

   function automatic logic [DW-1:0] init_word(input int a);
      return 16'hA500 + 16'(a * 3);
   endfunction

   task automatic model_reset();
      m_lock = -1; m_ptr = 0; m_cnt = 0; m_pend = 0; m_owner = 0; m_pdata = '0;
   endtask

   task automatic model_eval();
      win = -1; e_to = 1'b0;
      if (!rst_n) model_reset();
      else if (m_lock < 0) begin
         if (i_v[0] && i_v[1]) win = m_ptr;
         else if (i_v[0])      win = 0;
         else if (i_v[1])      win = 1;
      end else begin
         if (i_v[m_lock]) win = m_lock;
         e_to = i_l[m_lock] && (m_cnt + 1 == LT);
      end
      e_g[0] = (win == 0);
      e_g[1] = (win == 1);
      e_we   = (win >= 0) ? i_we[win] : 1'b0;
      e_addr = (win >= 0) ? i_a[win]  : '0;
      e_data = (win >= 0) ? i_d[win]  : '0;
      e_rv[0] = m_pend && (m_owner == 0);
      e_rv[1] = m_pend && (m_owner == 1);
      e_rd[0] = e_rv[0] ? m_pdata : '0;
      e_rd[1] = e_rv[1] ? m_pdata : '0;
      exp_c = {e_g[0], e_g[1], e_to, e_we, e_rv[0], e_rv[1]};
      exp_d = {e_addr, e_data, e_rd[0], e_rd[1]};
   endtask

   task automatic model_commit();
      int i;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_lock < 0) begin
         if (win >= 0) begin
            if (i_l[win]) begin m_lock = win; m_cnt = 0; end
            else m_ptr = 1 - win;
         end
      end else begin
         i = m_lock;
         if (!i_l[i] || m_cnt + 1 == LT) begin
            m_lock = -1; m_ptr = 1 - i; m_cnt = 0;
         end else m_cnt++;
      end
      m_pend = (win >= 0) && !i_we[win];
      if (m_pend) begin
         m_owner = win;
         m_pdata = shadow[i_a[win]];
      end
      if (win >= 0 && i_we[win]) shadow[i_a[win]] = i_d[win];
   endtask

   task automatic set_req(input int p, input bit v, input bit we, input int a, input int d, input bit l);
      i_v[p] = v; i_we[p] = we; i_a[p] = AW'(a); i_d[p] = DW'(d); i_l[p] = l;
   endtask

   task automatic sample();
      #1;
      model_eval();
      got_c = {bus.req0_grant, bus.req1_grant, bus.lock_timeout, bus.mem_we,
               bus.req0_rvalid, bus.req1_rvalid};
      got_d = {bus.mem_addr, bus.mem_data, bus.req0_rdata, bus.req1_rdata};
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         set_req(0, 0, 0, 0, 0, 0);
         set_req(1, 0, 0, 0, 0, 0);
         sample();
         model_commit();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      set_req(0, 1, 0, 5, 0, 0);
      set_req(1, 1, 0, 9, 0, 0);
      sample();
      tests_run++;
      if (got_c !== 6'b0) begin
         tests_failed++; $display("FAIL reset_ctrl got=%b exp=%b", got_c, 6'b0);
      end
      tests_run++;
      if ({bus.mem_addr, bus.mem_data} !== 22'd0) begin
         tests_failed++; $display("FAIL reset_bus got=%h exp=0", {bus.mem_addr, bus.mem_data});
      end
      @(negedge clk);
      rst_n = 1'b1;
      sample();
      tests_run++;
      if ({bus.req0_grant, bus.req1_grant} !== 2'b10) begin
         tests_failed++; $display("FAIL reset_first_grant got=%b exp=10", {bus.req0_grant, bus.req1_grant});
      end
      model_commit();
      @(negedge clk);
      set_req(0, 0, 0, 0, 0, 0);
      sample();
      model_commit();
      idle_cycles(1);
   endtask

   task automatic test_contention();
      logic [1:0] exp_g;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         set_req(0, k < 8, 0, 5, 0, 0);
         set_req(1, k < 8, 0, 9, 0, 0);
         sample();
         if (k < 8) begin
            exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
            tests_run++;
            if ({bus.req0_grant, bus.req1_grant} !== exp_g) begin
               tests_failed++; $display("FAIL contention_grant k=%0d got=%b exp=%b", k, {bus.req0_grant, bus.req1_grant}, exp_g);
            end
         end
         if (k > 0) begin
            tests_run++;
            if ((k - 1) % 2 == 0) begin
               if ({bus.req0_rvalid, bus.req1_rvalid, bus.req0_rdata} !== {2'b10, init_word(5)}) begin
                  tests_failed++; $display("FAIL contention_rd0 k=%0d got=%b %h exp=10 %h", k, {bus.req0_rvalid, bus.req1_rvalid}, bus.req0_rdata, init_word(5));
               end
            end else begin
               if ({bus.req0_rvalid, bus.req1_rvalid, bus.req1_rdata} !== {2'b01, init_word(9)}) begin
                  tests_failed++; $display("FAIL contention_rd1 k=%0d got=%b %h exp=01 %h", k, {bus.req0_rvalid, bus.req1_rvalid}, bus.req1_rdata, init_word(9));
               end
            end
         end
         model_commit();
      end
   endtask

   task automatic test_lock();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         case (c)
            0:       set_req(0, 1, 0, 3, 0, 1);
            1, 2:    set_req(0, 0, 0, 0, 0, 1);
            3:       set_req(0, 1, 1, 4, 16'h00AA, 0);
            default: set_req(0, 0, 0, 0, 0, 0);
         endcase
         set_req(1, c < 5, 0, 20, 0, 0);
         sample();
         if (c < 4) begin
            tests_run++;
            if ({bus.req0_grant, bus.req1_grant} !== {(c == 0 || c == 3), 1'b0}) begin
               tests_failed++; $display("FAIL lock_hold c=%0d got=%b exp=%b0", c, {bus.req0_grant, bus.req1_grant}, (c == 0 || c == 3));
            end
         end
         if (c == 1) begin
            tests_run++;
            if ({bus.req0_rvalid, bus.req0_rdata} !== {1'b1, init_word(3)}) begin
               tests_failed++; $display("FAIL lock_read got=%b %h exp=1 %h", bus.req0_rvalid, bus.req0_rdata, init_word(3));
            end
         end
         if (c == 4) begin
            tests_run++;
            if (bus.req1_grant !== 1'b1) begin
               tests_failed++; $display("FAIL lock_release_grant got=%b exp=1", bus.req1_grant);
            end
            tests_run++;
            if (tb_mem[4] !== 16'h00AA) begin
               tests_failed++; $display("FAIL lock_write got=%h exp=00aa", tb_mem[4]);
            end
         end
         if (c == 5) begin
            tests_run++;
            if ({bus.req1_rvalid, bus.req1_rdata} !== {1'b1, init_word(20)}) begin
               tests_failed++; $display("FAIL lock_p1_read got=%b %h exp=1 %h", bus.req1_rvalid, bus.req1_rdata, init_word(20));
            end
         end
         model_commit();
      end
   endtask

   task automatic test_timeout();
      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         set_req(1, 1, 0, 7, 0, 1);
         set_req(0, k > 0, 0, 8, 0, 0);
         sample();
         tests_run++;
         if ({bus.lock_timeout, bus.req0_grant, bus.req1_grant} !== {(k == 15), (k == 16), (k <= 15)}) begin
            tests_failed++;
            $display("FAIL timeout k=%0d got=%b exp=%b", k, {bus.lock_timeout, bus.req0_grant, bus.req1_grant}, {(k == 15), (k == 16), (k <= 15)});
         end
         model_commit();
      end
      idle_cycles(2);
   endtask

   task automatic test_single();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         set_req(0, 0, 0, 0, 0, 0);
         if (c == 0)      set_req(1, 1, 1, 62, 16'h1234, 0);
         else if (c == 1) set_req(1, 1, 0, 62, 0, 0);
         else             set_req(1, 0, 0, 0, 0, 0);
         sample();
         tests_run++;
         if (c < 2 && bus.req1_grant !== 1'b1) begin
            tests_failed++; $display("FAIL single_grant c=%0d got=%b exp=1", c, bus.req1_grant);
         end
         if (c == 2) begin
            tests_run++;
            if ({bus.req0_rvalid, bus.req1_rvalid, bus.req1_rdata, bus.req0_rdata} !== {2'b01, 16'h1234, 16'h0}) begin
               tests_failed++; $display("FAIL single_read got=%b %h %h exp=01 1234 0000", {bus.req0_rvalid, bus.req1_rvalid}, bus.req1_rdata, bus.req0_rdata);
            end
         end
         model_commit();
      end
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk);
      set_req(0, 1, 1, 11, 16'h5555, 0);
      sample();
      model_commit();
      @(negedge clk);
      set_req(0, 1, 0, 10, 0, 1);
      sample();
      tests_run++;
      if (bus.req0_grant !== 1'b1) begin
         tests_failed++; $display("FAIL midread_grant got=%b exp=1", bus.req0_grant);
      end
      model_commit();
      @(posedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      #1;
      tests_run++;
      if ({bus.req0_rvalid, bus.req1_rvalid, bus.req0_grant} !== 3'b000) begin
         tests_failed++; $display("FAIL midread_in_reset got=%b exp=000", {bus.req0_rvalid, bus.req1_rvalid, bus.req0_grant});
      end
      @(negedge clk);
      rst_n = 1'b1;
      set_req(0, 0, 0, 0, 0, 0);
      sample();
      tests_run++;
      if ({bus.req0_rvalid, bus.req1_rvalid} !== 2'b00) begin
         tests_failed++; $display("FAIL midread_after_release got=%b exp=00", {bus.req0_rvalid, bus.req1_rvalid});
      end
      model_commit();
      @(negedge clk);
      set_req(0, 1, 0, 12, 0, 0);
      set_req(1, 1, 0, 13, 0, 0);
      sample();
      tests_run++;
      if ({bus.req0_grant, bus.req1_grant} !== 2'b10) begin
         tests_failed++; $display("FAIL midread_ptr got=%b exp=10", {bus.req0_grant, bus.req1_grant});
      end
      model_commit();
      @(negedge clk);
      set_req(0, 0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0, 0);
      sample();
      tests_run++;
      if ({bus.req0_rvalid, bus.req0_rdata} !== {1'b1, init_word(12)}) begin
         tests_failed++; $display("FAIL midread_next_read got=%b %h exp=1 %h", bus.req0_rvalid, bus.req0_rdata, init_word(12));
      end
      model_commit();
      idle_cycles(1);
   endtask

   task automatic test_random();
      bit hold[2];
      hold[0] = 0; hold[1] = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (!hold[p]) begin
               if ($urandom_range(0, 3) != 0) begin
                  set_req(p, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                          $urandom_range(0, 16'hFFFF), ($urandom_range(0, 2) == 0));
                  hold[p] = 1;
               end else begin
                  set_req(p, 0, 0, 0, 0, i_l[p] && ($urandom_range(0, 3) != 0));
               end
            end
         end
         sample();
         tests_run++;
         if (got_c !== exp_c) begin
            tests_failed++; $display("FAIL random_ctrl k=%0d got=%b exp=%b", k, got_c, exp_c);
         end
         tests_run++;
         if (got_d !== exp_d) begin
            tests_failed++; $display("FAIL random_data k=%0d got=%h exp=%h", k, got_d, exp_d);
         end
         for (int p = 0; p < 2; p++) if (e_g[p]) hold[p] = 0;
         model_commit();
      end
   endtask

   initial begin
      for (int a = 0; a < 64; a++) begin
         tb_mem[a] = init_word(a);
         shadow[a] = init_word(a);
      end
      set_req(0, 0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0, 0);
      test_reset();
      test_contention();
      test_lock();
      test_timeout();
      test_single();
      test_reset_mid_read();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
